requant_share_scheduler: RTL

Round-robin scheduler that shares one combinational rounding/saturation unit (`rounding_overflow_arith`) among NUM_REQ filter-stage accumulators. It accepts full-precision accumulator words over valid/ready handshakes and drives the shared unit's input through a register stage. It captures the rounded result, tagged with the requester ID, into a back-pressurable output register. It also keeps per-requester sticky saturation flags and saturating overflow/underflow event counters for the DFE status block.

---
 rtl/requant_share_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/requant_share_scheduler.sv
// Round-robin arbiter feeding one shared rounding/saturation unit through a
// register stage, with a back-pressurable result register and saturation stats.
module requant_share_scheduler #(
  parameter  int NUM_REQ   = 4,
  parameter  int ACC_WIDTH = 42,
  parameter  int OUT_WIDTH = 16,
  parameter  int CNT_WIDTH = 16,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ACC_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ACC_WIDTH-1:0]           ru_data_in,
  output logic                           ru_valid_in,
  input  logic [OUT_WIDTH-1:0]           ru_data_out,
  input  logic                           ru_overflow,
  input  logic                           ru_underflow,
  output logic                           out_valid,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]                out_id,
  input  logic                           out_ready,
  input  logic                           sat_clear,
  output logic [NUM_REQ-1:0]             sat_flag,
  output logic [CNT_WIDTH-1:0]           ovf_cnt,
  output logic [CNT_WIDTH-1:0]           unf_cnt,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;

  state_e                 state_q;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ACC_WIDTH-1:0]   ru_data_q;
  logic                   ru_vld_q;
  logic [ID_W-1:0]        s0_id_q;
  logic [OUT_WIDTH-1:0]   out_data_q;
  logic                   out_vld_q;
  logic [ID_W-1:0]        out_id_q;
  logic [NUM_REQ-1:0]     sat_flag_q, sat_flag_d;
  logic [CNT_WIDTH-1:0]   ovf_q, ovf_d, unf_q, unf_d;

  logic                   adv, pipe_busy, gnt_vld;
  logic [ID_W-1:0]        gnt_id;
  logic [NUM_REQ-1:0]     gnt_oh;
  logic [ID_W:0]          cand;
  logic [ACC_WIDTH-1:0]   gnt_word;

  assign adv       = !out_vld_q || out_ready;
  assign pipe_busy = ru_vld_q || out_vld_q;

  // Search upward from ptr; cand has one spare bit so the wrap is a subtract.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    cand    = '0;
    if (adv && state_q == ACTIVE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
        if (!gnt_vld && req_valid[cand[ID_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_id  = cand[ID_W-1:0];
        end
      end
      gnt_oh[gnt_id] = gnt_vld;
    end
  end

  assign gnt_word = req_data[gnt_id*ACC_WIDTH +: ACC_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
  end

  // Clear first, then apply this cycle's event so a colliding event survives.
  always_comb begin
    sat_flag_d = sat_clear ? '0 : sat_flag_q;
    ovf_d      = sat_clear ? '0 : ovf_q;
    unf_d      = sat_clear ? '0 : unf_q;
    if (adv && ru_vld_q) begin
      if (ru_overflow  && ovf_d != {CNT_WIDTH{1'b1}}) ovf_d = ovf_d + CNT_WIDTH'(1);
      if (ru_underflow && unf_d != {CNT_WIDTH{1'b1}}) unf_d = unf_d + CNT_WIDTH'(1);
      if (ru_overflow || ru_underflow) sat_flag_d[s0_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ru_data_q  <= '0;
      ru_vld_q   <= 1'b0;
      s0_id_q    <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      sat_flag_q <= '0;
      ovf_q      <= '0;
      unf_q      <= '0;
    end else begin
      case (state_q)
        IDLE:    if (en) state_q <= ACTIVE;
        ACTIVE:  if (!en) state_q <= pipe_busy ? DRAIN : IDLE;
        DRAIN:   if (en) state_q <= ACTIVE;
                 else if (!pipe_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      ptr_q <= ptr_d;
      // S1 captures the rounding result of S0 while S0 takes the new grant.
      if (adv) begin
        out_data_q <= ru_data_out;
        out_vld_q  <= ru_vld_q;
        out_id_q   <= s0_id_q;
        ru_vld_q   <= gnt_vld;
        if (gnt_vld) begin
          ru_data_q <= gnt_word;
          s0_id_q   <= gnt_id;
        end
      end
      sat_flag_q <= sat_flag_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign req_ready   = gnt_oh;
  assign ru_data_in  = ru_data_q;
  assign ru_valid_in = ru_vld_q;
  assign out_valid   = out_vld_q;
  assign out_data    = out_data_q;
  assign out_id      = out_id_q;
  assign sat_flag    = sat_flag_q;
  assign ovf_cnt     = ovf_q;
  assign unf_cnt     = unf_q;
  assign busy        = (state_q != IDLE);

endmodule
